// File: rtl/axi_mem_slave.sv
// AXI3/AXI4 memory slave with independent read/write burst FSMs (FIXED/INCR/WRAP, strobes, ID echo).
// Define AXI_MEM_SLVERR_EN to flag out-of-range accesses and wlast mismatches with SLVERR.
module axi_mem_slave #(
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 256,
    parameter int BURST_LEN_WIDTH = 4
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [ID_WIDTH-1:0]        awid,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic [BURST_LEN_WIDTH-1:0] awlen,
    input  logic [1:0]                 awburst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [ID_WIDTH-1:0]        bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ID_WIDTH-1:0]        arid,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [BURST_LEN_WIDTH-1:0] arlen,
    input  logic [1:0]                 arburst,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [ID_WIDTH-1:0]        rid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready
);

`ifdef AXI_MEM_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_BITS   = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [IDX_BITS-1:0]        idx_t;
    typedef logic [BURST_LEN_WIDTH-1:0] len_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    function automatic idx_t word_of(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFF_BITS +: IDX_BITS];
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        logic oor;
        oor = 1'b0;
        for (int i = OFF_BITS + IDX_BITS; i < ADDR_WIDTH; i++) oor |= addr[i];
        return oor;
    endfunction

    // WRAP with an illegal length degrades to INCR rather than erroring.
    function automatic idx_t next_word(input idx_t word, input len_t len, input logic [1:0] burst);
        idx_t mask;
        logic wrap_ok;
        mask    = idx_t'(len);
        wrap_ok = (len == len_t'(1)) || (len == len_t'(3)) || (len == len_t'(7)) || (len == len_t'(15));
        if (burst == BURST_FIXED) return word;
        if (burst == BURST_WRAP && wrap_ok) return (word & ~mask) | ((word + idx_t'(1)) & mask);
        return word + idx_t'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t w_state;
    idx_t     w_word;
    len_t     w_len, w_beat;
    logic [1:0] w_burst;
    logic     w_oor, w_err;
    logic     w_last_beat, w_beat_err, w_fire;

    assign w_last_beat = (w_beat == w_len);
    assign w_beat_err  = SLVERR_EN && (w_oor || (wlast != w_last_beat));
    assign w_fire      = (w_state == W_DATA) && wvalid && !w_oor;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_word  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= BURST_FIXED;
            w_oor   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid) begin
                    bid     <= awid;
                    w_word  <= word_of(awaddr);
                    w_len   <= awlen;
                    w_burst <= awburst;
                    w_beat  <= '0;
                    w_oor   <= SLVERR_EN && out_of_range(awaddr);
                    w_err   <= 1'b0;
                    awready <= 1'b0;
                    wready  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    w_word <= next_word(w_word, w_len, w_burst);
                    w_beat <= w_beat + len_t'(1);
                    w_err  <= w_err || w_beat_err;
                    if (w_last_beat) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the storage array deliberately has no reset; contents survive areset_n.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) mem[w_word][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    r_state_t   r_state;
    idx_t       r_word, r_next, ar_word;
    len_t       r_len, r_beat;
    logic [1:0] r_burst;
    logic       r_oor, ar_oor;

    assign ar_word = word_of(araddr);
    assign ar_oor  = SLVERR_EN && out_of_range(araddr);
    assign r_next  = next_word(r_word, r_len, r_burst);

    // rdata is captured at the edge, so a same-cycle write to that word is seen on the next fetch.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            r_word  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= BURST_FIXED;
            r_oor   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    rid     <= arid;
                    r_word  <= ar_word;
                    r_len   <= arlen;
                    r_burst <= arburst;
                    r_beat  <= '0;
                    r_oor   <= ar_oor;
                    rdata   <= ar_oor ? '0 : mem[ar_word];
                    rresp   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
                    rlast   <= (arlen == '0);
                    rvalid  <= 1'b1;
                    arready <= 1'b0;
                    r_state <= R_DATA;
                end
                R_DATA: if (rready) begin
                    if (rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_word <= r_next;
                        r_beat <= r_beat + len_t'(1);
                        rdata  <= r_oor ? '0 : mem[r_next];
                        rlast  <= (r_beat + len_t'(1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
